// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master controller.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Width of the slave-select index; never below one bit.
  function automatic int ss_w(input int num_ss);
    return (num_ss > 1) ? $clog2(num_ss) : 1;
  endfunction

endpackage

// File: rtl/spi_hp_tick.sv
// Half-period strobe: one-cycle pulse every CLK_DIV clocks while enabled.
module spi_hp_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic hp_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign hp_tick = en && (cnt == '0);

  // Down-counter; parked at the reload value while disabled so the first
  // enabled half-period is a full CLK_DIV cycles long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || (cnt == '0)) begin
      cnt <= CW'(CLK_DIV - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Parametrised SPI master: valid/ready word in, MOSI/MISO shift, one-hot
// active-low selects and a forced deselect gap between transfers.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_SS  = 1,
  parameter int CLK_DIV = 4,
  parameter int GAP_HP  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic [ss_w(NUM_SS)-1:0] ss_sel,
  input  logic                    cpol,
  input  logic                    cpha,
  output logic                    rx_valid,
  output logic [DATA_W-1:0]       rx_data,
  output logic                    busy,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso,
  output logic [NUM_SS-1:0]       ss
);

  localparam int SS_W    = ss_w(NUM_SS);
  localparam int EDGES   = 2 * DATA_W;
  localparam int CNT_MAX = (EDGES > GAP_HP) ? EDGES : GAP_HP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  spi_state_t        state, nxt;
  spi_mode_t         mode_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              hp_tick, accept, last_edge, gap_done, leading, sample_edge;

  // Out-of-range indices leave every line deasserted.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(sel) == i) v[i] = 1'b0;
    end
    return v;
  endfunction

  assign tx_ready    = (state == IDLE) && !rst;
  assign busy        = (state != IDLE);
  assign accept      = tx_valid && tx_ready;
  assign last_edge   = (cnt == CNT_W'(EDGES - 1));
  assign gap_done    = (cnt == CNT_W'(GAP_HP - 1));
  // cnt holds edges already made, so an even count means the next is odd (leading).
  assign leading     = ~cnt[0];
  assign sample_edge = leading ^ mode_q.cpha;

  spi_hp_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .hp_tick (hp_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state decode; every non-idle state advances on half-period ticks.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = SETUP;
      SETUP:   if (hp_tick) nxt = SHIFT;
      SHIFT:   if (hp_tick && last_edge) nxt = HOLD;
      HOLD:    if (hp_tick) nxt = GAP;
      GAP:     if (hp_tick && gap_done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Edge counter in SHIFT, half-period counter in GAP; cleared on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state != nxt) begin
      cnt <= '0;
    end else if (hp_tick) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pin drivers and shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss       <= '1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      mode_q   <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (accept) begin
            mode_q <= '{cpol: cpol, cpha: cpha};
            ss     <= ss_decode(ss_sel);
            rx_sr  <= '0;
            // With cpha=0 the MSB goes out now, so the register holds the rest.
            if (cpha) begin
              tx_sr <= tx_data;
            end else begin
              tx_sr <= tx_data << 1;
              mosi  <= tx_data[DATA_W-1];
            end
          end
        end
        SHIFT: begin
          if (hp_tick) begin
            sclk <= ~sclk;
            if (sample_edge) begin
              rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end else if (!last_edge) begin
              mosi  <= tx_sr[DATA_W-1];
              tx_sr <= tx_sr << 1;
            end
          end
        end
        HOLD: begin
          sclk <= mode_q.cpol;
          if (hp_tick) begin
            ss       <= '1;
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: three parameterisations sharing one clock.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DUT a: DATA_W=16, NUM_SS=4, CLK_DIV=2
  logic        rst_a, a_tx_valid, a_tx_ready, a_cpol, a_cpha, a_rx_valid, a_busy;
  logic        a_sclk, a_mosi, a_miso, a_loop, a_slv_bit;
  logic [15:0] a_tx_data, a_rx_data;
  logic [1:0]  a_ss_sel;
  logic [3:0]  a_ss;
  // DUT b: DATA_W=16, NUM_SS=1, CLK_DIV=1
  logic        rst_bc, b_tx_valid, b_tx_ready, b_cpol, b_cpha, b_rx_valid, b_busy;
  logic        b_sclk, b_mosi;
  logic [15:0] b_tx_data, b_rx_data;
  logic [0:0]  b_ss_sel, b_ss;
  // DUT c: DATA_W=8, NUM_SS=1, CLK_DIV=3
  logic        c_tx_valid, c_tx_ready, c_cpol, c_cpha, c_rx_valid, c_busy;
  logic        c_sclk, c_mosi;
  logic [7:0]  c_tx_data, c_rx_data;
  logic [0:0]  c_ss_sel, c_ss;

  assign a_miso = a_loop ? a_mosi : a_slv_bit;

  spi_master_ctrl #(.DATA_W(16), .NUM_SS(4), .CLK_DIV(2), .GAP_HP(1)) u_a (
    .clk(clk), .rst(rst_a), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx_data(a_tx_data), .ss_sel(a_ss_sel), .cpol(a_cpol), .cpha(a_cpha),
    .rx_valid(a_rx_valid), .rx_data(a_rx_data), .busy(a_busy), .sclk(a_sclk),
    .mosi(a_mosi), .miso(a_miso), .ss(a_ss));

  spi_master_ctrl #(.DATA_W(16), .NUM_SS(1), .CLK_DIV(1), .GAP_HP(1)) u_b (
    .clk(clk), .rst(rst_bc), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx_data(b_tx_data), .ss_sel(b_ss_sel), .cpol(b_cpol), .cpha(b_cpha),
    .rx_valid(b_rx_valid), .rx_data(b_rx_data), .busy(b_busy), .sclk(b_sclk),
    .mosi(b_mosi), .miso(b_mosi), .ss(b_ss));

  spi_master_ctrl #(.DATA_W(8), .NUM_SS(1), .CLK_DIV(3), .GAP_HP(1)) u_c (
    .clk(clk), .rst(rst_bc), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .tx_data(c_tx_data), .ss_sel(c_ss_sel), .cpol(c_cpol), .cpha(c_cpha),
    .rx_valid(c_rx_valid), .rx_data(c_rx_data), .busy(c_busy), .sclk(c_sclk),
    .mosi(c_mosi), .miso(c_mosi), .ss(c_ss));

  // Scoreboards: expected words pushed at stimulus, observed words collected by the monitor.
  logic [15:0] qa[$], qb[$], qc[$];
  logic [15:0] obs_a[$], obs_b[$], obs_c[$];
  int ia = 0, ib = 0, ic = 0;
  int a_dbl = 0, b_dbl = 0, c_dbl = 0;
  logic a_rxv_prev = 1'b0, b_rxv_prev = 1'b0, c_rxv_prev = 1'b0;
  logic b_mon = 1'b0;
  int b_run = 0, b_min = 1000;
  logic b_seen = 1'b0;

  // Slave for DUT a: MSB presented on select, next bit after each trailing edge.
  logic [15:0] s_pat;
  int s_idx = 0;
  logic s_prev = 1'b0;
  always @(negedge clk) begin
    if (a_ss == 4'hF) s_idx = 0;
    else if (a_sclk != s_prev && a_sclk == a_cpol) s_idx++;
    s_prev = a_sclk;
    a_slv_bit = (s_idx < 16) ? s_pat[4'(15 - s_idx)] : 1'b0;
  end

  // Output monitor.
  always @(negedge clk) begin
    if (a_rx_valid) begin obs_a.push_back(a_rx_data); if (a_rxv_prev) a_dbl++; end
    if (b_rx_valid) begin obs_b.push_back(b_rx_data); if (b_rxv_prev) b_dbl++; end
    if (c_rx_valid) begin obs_c.push_back({8'h00, c_rx_data}); if (c_rxv_prev) c_dbl++; end
    a_rxv_prev = a_rx_valid;
    b_rxv_prev = b_rx_valid;
    c_rxv_prev = c_rx_valid;
    if (!b_mon) begin
      b_run = 0; b_seen = 1'b0; b_min = 1000;
    end else if (b_ss[0]) begin
      b_run++;
    end else begin
      if (b_seen && b_run > 0 && b_run < b_min) b_min = b_run;
      b_seen = 1'b1;
      b_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_a(input string tag);
    int n = 0;
    while (obs_a.size() <= ia && n < 3000) begin @(negedge clk); n++; end
    if (obs_a.size() > ia) begin chk(tag, obs_a[ia], qa.pop_front()); ia++; end
    else chk({tag, "_timeout"}, obs_a.size(), ia + 1);
  endtask

  task automatic sb_b(input string tag);
    int n = 0;
    while (obs_b.size() <= ib && n < 3000) begin @(negedge clk); n++; end
    if (obs_b.size() > ib) begin chk(tag, obs_b[ib], qb.pop_front()); ib++; end
    else chk({tag, "_timeout"}, obs_b.size(), ib + 1);
  endtask

  task automatic sb_c(input string tag);
    int n = 0;
    while (obs_c.size() <= ic && n < 3000) begin @(negedge clk); n++; end
    if (obs_c.size() > ic) begin chk(tag, obs_c[ic], qc.pop_front()); ic++; end
    else chk({tag, "_timeout"}, obs_c.size(), ic + 1);
  endtask

  // Wait for ready, present one request for one cycle, then scramble the inputs.
  task automatic start_a(input logic [15:0] d, input logic [1:0] sel, input logic p, input logic h);
    int n = 0;
    while (a_tx_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk("a_ready_wait", a_tx_ready, 1);
    a_tx_data = d; a_ss_sel = sel; a_cpol = p; a_cpha = h; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    a_tx_data = ~d; a_ss_sel = ~sel; a_cpha = ~h;
  endtask

  // Observe DUT a from the first SETUP cycle until the selects release.
  task automatic run_a(input logic [3:0] exp_ss, input logic mosi_fall,
                       output int low_cyc, output int toggles, output int bad_ss, output int bad_mosi);
    logic ps, pm;
    int n;
    low_cyc = 0; toggles = 0; bad_ss = 0; bad_mosi = 0; n = 0;
    ps = a_sclk; pm = a_mosi;
    while (a_ss != 4'hF && n < 500) begin
      low_cyc++;
      if (a_ss !== exp_ss) bad_ss++;
      if (a_sclk != ps) toggles++;
      if (mosi_fall && a_mosi != pm && !(ps == 1'b1 && a_sclk == 1'b0)) bad_mosi++;
      ps = a_sclk; pm = a_mosi;
      @(negedge clk); n++;
    end
  endtask

  initial begin
    int lc, tg, bs, bm, n, m, k, t3;
    logic ps;
    logic [15:0] w[3];
    w[0] = 16'h0001; w[1] = 16'h8000; w[2] = 16'h5555;
    rst_a = 1'b1; rst_bc = 1'b1; a_loop = 1'b1; s_pat = 16'h0000;
    a_tx_valid = 0; a_tx_data = 0; a_ss_sel = 0; a_cpol = 0; a_cpha = 0;
    b_tx_valid = 0; b_tx_data = 0; b_ss_sel = 0; b_cpol = 0; b_cpha = 0;
    c_tx_valid = 0; c_tx_data = 0; c_ss_sel = 0; c_cpol = 0; c_cpha = 0;
    repeat (3) @(negedge clk);

    chk("rst_a_ctrl", {a_tx_ready, a_busy, a_rx_valid, a_sclk, a_mosi}, 5'b00000);
    chk("rst_a_ss", a_ss, 4'hF);
    chk("rst_a_rx", a_rx_data, 0);
    chk("rst_b", {b_tx_ready, b_busy, b_rx_valid, b_sclk, b_mosi, b_ss, b_rx_data}, 22'h010000);
    chk("rst_c", {c_tx_ready, c_busy, c_rx_valid, c_sclk, c_mosi, c_ss, c_rx_data}, 14'h0100);
    rst_a = 1'b0; rst_bc = 1'b0;
    @(negedge clk);
    chk("idle_a", {a_tx_ready, a_busy, a_ss}, 6'b101111);

    // Mode 3 slave pattern, select index 2.
    a_loop = 1'b0; s_pat = 16'h1234; a_cpol = 1'b1; a_cpha = 1'b1;
    repeat (2) @(negedge clk);
    chk("m3_idle_sclk", a_sclk, 1);
    start_a(16'hFFFF, 2'd2, 1'b1, 1'b1);
    qa.push_back(16'h1234);
    chk("m3_setup_sclk", a_sclk, 1);
    run_a(4'b1011, 1'b1, lc, tg, bs, bm);
    chk("m3_ss_low_cyc", lc, 68);
    chk("m3_toggles", tg, 32);
    chk("m3_ss_value", bs, 0);
    chk("m3_mosi_on_fall", bm, 0);
    chk("m3_end_sclk", a_sclk, 1);
    chk("m3_ss_high", a_ss, 4'hF);
    sb_a("m3_rx");

    // Mode 0 loopback, select index 0.
    a_loop = 1'b1; a_cpol = 1'b0;
    start_a(16'hA5C3, 2'd0, 1'b0, 1'b0);
    qa.push_back(16'hA5C3);
    chk("m0_setup_sclk", a_sclk, 0);
    run_a(4'b1110, 1'b0, lc, tg, bs, bm);
    chk("m0_ss_low_cyc", lc, 68);
    chk("m0_toggles", tg, 32);
    chk("m0_ss_value", bs, 0);
    chk("m0_end_sclk", a_sclk, 0);
    sb_a("m0_rx");

    // Mode 1 transfer aborted by reset after the tenth sclk edge.
    start_a(16'hBEEF, 2'd1, 1'b0, 1'b1);
    ps = a_sclk; tg = 0; n = 0;
    while (tg < 10 && n < 200) begin
      @(negedge clk); n++;
      if (a_sclk != ps) tg++;
      ps = a_sclk;
    end
    chk("rst_edge_count", tg, 10);
    rst_a = 1'b1;
    #1;
    chk("rst_mid_ss", a_ss, 4'hF);
    chk("rst_mid_sclk", a_sclk, 0);
    chk("rst_mid_ctrl", {a_busy, a_tx_ready, a_rx_data}, 18'h0);
    @(negedge clk);
    rst_a = 1'b0;
    start_a(16'h0F0F, 2'd3, 1'b0, 1'b1);
    qa.push_back(16'h0F0F);
    run_a(4'b0111, 1'b0, lc, tg, bs, bm);
    chk("m1_ss_low_cyc", lc, 68);
    chk("m1_toggles", tg, 32);
    chk("m1_ss_value", bs, 0);
    sb_a("m1_rx");
    repeat (4) @(negedge clk);
    chk("rst_no_rx_count", obs_a.size(), ia);

    // DUT b: out-of-range select index leaves ss high, data still loops.
    n = 0;
    while (b_tx_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    b_tx_data = 16'h3C96; b_ss_sel = 1'b1; b_tx_valid = 1'b1;
    qb.push_back(16'h3C96);
    @(negedge clk);
    b_tx_valid = 1'b0;
    n = 0; bs = 0;
    while (b_busy && n < 200) begin
      if (b_ss !== 1'b1) bs++;
      @(negedge clk); n++;
    end
    chk("b_oor_ss", bs, 0);
    chk("b_oor_busy_len", n, 35);
    sb_b("b_oor_rx");

    // DUT b: three words with tx_valid held high.
    b_ss_sel = 1'b0; b_mon = 1'b1;
    n = 0;
    while (b_tx_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    b_tx_data = w[0]; b_tx_valid = 1'b1;
    k = 0; n = 0; t3 = -1;
    while (k < 3 && n < 500) begin
      if (b_tx_ready) begin
        qb.push_back(w[k]);
        if (k == 2) t3 = n;
        k++;
        @(negedge clk); n++;
        chk("b2b_ready_drop", b_tx_ready, 0);
        if (k < 3) b_tx_data = w[k];
        else b_tx_valid = 1'b0;
      end else begin
        @(negedge clk); n++;
      end
    end
    chk("b2b_accepts", k, 3);
    chk("b2b_third_accept", t3, 72);
    sb_b("b2b_rx0");
    sb_b("b2b_rx1");
    sb_b("b2b_rx2");
    chk("b2b_min_ss_high", b_min, 2);
    b_mon = 1'b0;

    // DUT c: DATA_W=8, CLK_DIV=3, mode 2 loopback.
    c_cpol = 1'b1; c_cpha = 1'b0;
    repeat (2) @(negedge clk);
    chk("c_idle_sclk", c_sclk, 1);
    c_tx_data = 8'h81; c_tx_valid = 1'b1;
    qc.push_back(16'h0081);
    @(negedge clk);
    c_tx_valid = 1'b0; c_tx_data = 8'h00;
    n = 1;
    while (c_ss !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("c_accept_to_ss_high", n, 55);
    chk("c_end_sclk", c_sclk, 1);
    m = 0;
    while (c_tx_ready !== 1'b1 && m < 100) begin @(negedge clk); m++; end
    chk("c_ready_return", m, 3);
    sb_c("c_rx");

    chk("a_single_pulse", a_dbl, 0);
    chk("b_single_pulse", b_dbl, 0);
    chk("c_single_pulse", c_dbl, 0);
    chk("sb_left", qa.size() + qb.size() + qc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
